vadd_kernel_sequencer: RTL and testbench

// Run controller for the vadd kernel: read master -> func_hdl_top datapath -> write master.

---
 rtl/vadd_kernel_sequencer_if.sv | 41 ++++
 rtl/vadd_kernel_sequencer.sv | 139 +++++++++++++
 tb/tb_vadd_kernel_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_kernel_sequencer_if.sv
// rtl/vadd_kernel_sequencer_if.sv - host handshake, run arguments, master control and status bundle
interface vadd_kernel_sequencer_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_TIMEOUT_WIDTH    = 32
);
  logic                          ap_start;
  logic                          ap_idle;
  logic                          ap_ready;
  logic                          ap_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset_rd;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset_wr;
  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
  logic [C_TIMEOUT_WIDTH-1:0]    ctrl_timeout_cycles;
  logic                          rd_start;
  logic                          wr_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_offset;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_in_bytes;
  logic                          read_done;
  logic                          write_done;
  logic                          mon_tvalid;
  logic                          mon_tready;
  logic [C_XFER_SIZE_WIDTH-1:0]  beat_count;
  logic                          err_beat_mismatch;
  logic                          err_timeout;

  modport slave (
    input  ap_start, ctrl_addr_offset_rd, ctrl_addr_offset_wr, ctrl_xfer_size_in_bytes,
           ctrl_timeout_cycles, read_done, write_done, mon_tvalid, mon_tready,
    output ap_idle, ap_ready, ap_done, rd_start, wr_start, rd_addr_offset, wr_addr_offset,
           xfer_size_in_bytes, beat_count, err_beat_mismatch, err_timeout
  );

  modport master (
    output ap_start, ctrl_addr_offset_rd, ctrl_addr_offset_wr, ctrl_xfer_size_in_bytes,
           ctrl_timeout_cycles, read_done, write_done, mon_tvalid, mon_tready,
    input  ap_idle, ap_ready, ap_done, rd_start, wr_start, rd_addr_offset, wr_addr_offset,
           xfer_size_in_bytes, beat_count, err_beat_mismatch, err_timeout
  );
endinterface

// File: rtl/vadd_kernel_sequencer.sv
// rtl/vadd_kernel_sequencer.sv - vadd run controller: ap_* handshake, master start, done join, beat check, watchdog
module vadd_kernel_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_TIMEOUT_WIDTH    = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  vadd_kernel_sequencer_if.slave bus
);
  localparam int AW         = C_M_AXI_ADDR_WIDTH;
  localparam int XW         = C_XFER_SIZE_WIDTH;
  localparam int TW         = C_TIMEOUT_WIDTH;
  localparam int BEAT_SHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [XW-1:0] BEAT_ONE = 1;
  localparam logic [TW-1:0] WD_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [XW-1:0] size_q, size_d, beat_q, beat_d, exp_beats;
  logic [TW-1:0] limit_q, limit_d, wd_q, wd_d;
  logic          rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic          err_beat_q, err_beat_d, err_to_q, err_to_d;
  logic          ready_q, ready_d, start_q, start_d;
  logic          beat_fire, pair_now, wd_hit;

  // Shift plus remainder-OR gives the ceiling without widening past XW.
  assign exp_beats = (size_q >> BEAT_SHIFT) + XW'(|size_q[BEAT_SHIFT-1:0]);
  assign beat_fire = bus.mon_tvalid & bus.mon_tready;
  assign pair_now  = (rd_seen_q | bus.read_done) & (wr_seen_q | bus.write_done);
  assign wd_hit    = (limit_q != '0) && ((wd_q + WD_ONE) == limit_q);

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    size_d     = size_q;
    limit_d    = limit_q;
    beat_d     = beat_q;
    wd_d       = wd_q;
    rd_seen_d  = rd_seen_q;
    wr_seen_d  = wr_seen_q;
    err_beat_d = err_beat_q;
    err_to_d   = err_to_q;
    ready_d    = 1'b0;
    start_d    = 1'b0;

    if ((state_q == S_START || state_q == S_RUN) && beat_fire && !(&beat_q)) begin
      beat_d = beat_q + BEAT_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          rd_addr_d  = bus.ctrl_addr_offset_rd;
          wr_addr_d  = bus.ctrl_addr_offset_wr;
          size_d     = bus.ctrl_xfer_size_in_bytes;
          limit_d    = bus.ctrl_timeout_cycles;
          beat_d     = '0;
          wd_d       = '0;
          rd_seen_d  = 1'b0;
          wr_seen_d  = 1'b0;
          err_beat_d = 1'b0;
          err_to_d   = 1'b0;
          ready_d    = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.read_done)  rd_seen_d = 1'b1;
        if (bus.write_done) wr_seen_d = 1'b1;
        if (!(&wd_q)) wd_d = wd_q + WD_ONE;
        // A done pair landing on the watchdog limit cycle still wins.
        if (rd_seen_q && wr_seen_q) begin
          state_d = S_DONE;
        end else if (wd_hit && !pair_now) begin
          err_to_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        err_beat_d = (beat_q != exp_beats);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      size_q     <= '0;
      limit_q    <= '0;
      beat_q     <= '0;
      wd_q       <= '0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      err_beat_q <= 1'b0;
      err_to_q   <= 1'b0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      size_q     <= size_d;
      limit_q    <= limit_d;
      beat_q     <= beat_d;
      wd_q       <= wd_d;
      rd_seen_q  <= rd_seen_d;
      wr_seen_q  <= wr_seen_d;
      err_beat_q <= err_beat_d;
      err_to_q   <= err_to_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
    end
  end

  assign bus.ap_idle            = (state_q == S_IDLE);
  assign bus.ap_ready           = ready_q;
  assign bus.ap_done            = (state_q == S_DONE);
  assign bus.rd_start           = start_q;
  assign bus.wr_start           = start_q;
  assign bus.rd_addr_offset     = rd_addr_q;
  assign bus.wr_addr_offset     = wr_addr_q;
  assign bus.xfer_size_in_bytes = size_q;
  assign bus.beat_count         = beat_q;
  assign bus.err_beat_mismatch  = err_beat_q;
  assign bus.err_timeout        = err_to_q;
endmodule

// File: tb/tb_vadd_kernel_sequencer.sv
// tb/tb_vadd_kernel_sequencer.sv - run-schedule model bench for vadd_kernel_sequencer
module tb_vadd_kernel_sequencer;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int TW = 32;
  localparam longint BPB = DW / 8;

  logic aclk;
  logic areset;
  int   total = 0;
  int   bad   = 0;

  vadd_kernel_sequencer_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW),
                             .C_TIMEOUT_WIDTH(TW)) bus ();

  vadd_kernel_sequencer #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
                          .C_XFER_SIZE_WIDTH(XW), .C_TIMEOUT_WIDTH(TW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Run schedule: accept edge a, done cycle d, beats inside (a, d], done pulses from edge a+2.
  int          cyc = 0;
  bit          run_act = 0, d_known = 0, rseen = 0, wseen = 0, m_to = 0, m_mm = 0;
  int          m_a = 0, m_d = 0;
  logic [63:0] m_rd = '0, m_wr = '0;
  logic [31:0] m_size = '0, m_lim = '0, m_cnt = '0;

  initial forever begin
    @(posedge aclk or posedge areset);
    if (areset) begin
      run_act = 0; d_known = 0; m_to = 0; m_mm = 0; m_cnt = '0;
      m_rd = '0; m_wr = '0; m_size = '0; m_lim = '0;
    end else begin
      cyc++;
      if (run_act) begin
        if (!d_known) begin
          if (cyc >= m_a + 2) begin
            if (bus.read_done)  rseen = 1;
            if (bus.write_done) wseen = 1;
          end
          if (rseen && wseen) begin
            m_d = cyc + 1; d_known = 1;
          end else if (m_lim != 0 && longint'(cyc) == longint'(m_a) + 1 + longint'(m_lim)) begin
            m_d = cyc; d_known = 1; m_to = 1;
          end
        end
        if (cyc >= m_a + 1 && (!d_known || cyc <= m_d) && bus.mon_tvalid && bus.mon_tready
            && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (d_known && cyc == m_d + 1)
          m_mm = (longint'(m_cnt) != (longint'(m_size) + BPB - 1) / BPB);
      end
      if (bus.ap_start && (!run_act || (d_known && cyc >= m_d + 2))) begin
        run_act = 1; d_known = 0; rseen = 0; wseen = 0; m_to = 0; m_mm = 0;
        m_a = cyc; m_cnt = '0;
        m_rd = bus.ctrl_addr_offset_rd; m_wr = bus.ctrl_addr_offset_wr;
        m_size = bus.ctrl_xfer_size_in_bytes; m_lim = bus.ctrl_timeout_cycles;
      end
    end
  end

  initial forever begin
    bit busy;
    @(negedge aclk);
    busy = run_act && (!d_known || cyc <= m_d);
    chk("ap_idle",      bus.ap_idle,  !busy);
    chk("ap_ready",     bus.ap_ready, run_act && cyc == m_a);
    chk("rd_start",     bus.rd_start, run_act && cyc == m_a + 1);
    chk("wr_start",     bus.wr_start, run_act && cyc == m_a + 1);
    chk("ap_done",      bus.ap_done,  run_act && d_known && cyc == m_d);
    chk("beat_count",   bus.beat_count, m_cnt);
    chk("err_timeout",  bus.err_timeout, m_to);
    chk("err_mismatch", bus.err_beat_mismatch, m_mm);
    chk("rd_addr",      bus.rd_addr_offset, m_rd);
    chk("wr_addr",      bus.wr_addr_offset, m_wr);
    chk("xfer_size",    bus.xfer_size_in_bytes, m_size);
  end

  task automatic do_run(input logic [31:0] size, input logic [31:0] lim, input int rd_dly,
                        input int wr_dly, input int nbeats, input bit noise, input bit hold,
                        input bit extra, output int st_cyc, output int rs_cyc, output int wd_cyc,
                        output int dn_cyc, output logic [31:0] bc, output bit e_mm,
                        output bit e_to, output int n_rs);
    bit ready_seen = 0, started = 0;
    int rel = 0;
    rs_cyc = -1; wd_cyc = -1; dn_cyc = -1; n_rs = 0; bc = '0; st_cyc = cyc;
    bus.ctrl_addr_offset_rd     = {$urandom, $urandom};
    bus.ctrl_addr_offset_wr     = {$urandom, $urandom};
    bus.ctrl_xfer_size_in_bytes = size;
    bus.ctrl_timeout_cycles     = lim;
    bus.ap_start                = 1'b1;
    for (int k = 0; k < 3000 && dn_cyc < 0; k++) begin
      @(negedge aclk);
      if (bus.ap_ready) ready_seen = 1;
      if (bus.rd_start) begin
        n_rs++;
        if (!started) begin started = 1; rel = 0; rs_cyc = cyc; end
      end else if (started) rel++;
      if (bus.ap_done) begin dn_cyc = cyc; bc = bus.beat_count; end
      bus.ap_start = hold | !ready_seen | (extra && started && rel == 5);
      if (started) begin
        bus.read_done  = (rel == rd_dly);
        bus.write_done = (rel == wr_dly);
      end else begin
        bus.read_done  = noise && ($urandom_range(0, 3) == 0);
        bus.write_done = noise && ($urandom_range(0, 3) == 0);
      end
      if (started && bus.write_done) wd_cyc = cyc;
      if (noise) begin
        bus.mon_tvalid = ($urandom_range(0, 1) == 1);
        bus.mon_tready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.mon_tvalid = started && rel < nbeats;
        bus.mon_tready = started && rel < nbeats;
      end
    end
    if (dn_cyc < 0) chk("run_completes", 0, 1);
    bus.read_done = 0; bus.write_done = 0; bus.mon_tvalid = 0; bus.mon_tready = 0;
    @(negedge aclk);
    e_mm = bus.err_beat_mismatch;
    e_to = bus.err_timeout;
    bus.ap_start = hold;
  endtask

  initial begin
    int st, rs, wd, dn, nrs, nd;
    logic [31:0] bc;
    bit emm, eto, found;
    areset = 1'b1;
    bus.ap_start = 0; bus.read_done = 0; bus.write_done = 0;
    bus.mon_tvalid = 0; bus.mon_tready = 0;
    bus.ctrl_addr_offset_rd = '0; bus.ctrl_addr_offset_wr = '0;
    bus.ctrl_xfer_size_in_bytes = '0; bus.ctrl_timeout_cycles = '0;
    repeat (3) @(negedge aclk);
    chk("reset_idle", bus.ap_idle, 1);
    chk("reset_beats", bus.beat_count, 0);
    areset = 1'b0;
    @(negedge aclk);

    do_run(32'd4096, 0, 70, 90, 64, 0, 0, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t1_start_latency", rs - st, 2);
    chk("t1_done_latency", dn - wd, 2);
    chk("t1_beats", bc, 64);
    chk("t1_mismatch", emm, 0);
    chk("t1_timeout", eto, 0);

    do_run(32'd64, 0, 10, 10, 1, 0, 0, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t2_done_latency", dn - wd, 2);
    chk("t2_beats", bc, 1);
    chk("t2_mismatch", emm, 0);

    do_run(32'd100, 0, 5, 8, 1, 0, 0, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t3_beats", bc, 1);
    chk("t3_mismatch", emm, 1);

    do_run(32'd640, 32'd50, 3, -1, 10, 0, 0, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t4_timeout", eto, 1);
    chk("t4_run_cycles", dn - rs, 50);
    chk("t4_mismatch", emm, 0);

    bus.ctrl_addr_offset_rd = 64'h1234_5678_9ABC_DEF0;
    bus.ctrl_xfer_size_in_bytes = 32'd1024;
    bus.ctrl_timeout_cycles = '0;
    bus.ap_start = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge aclk);
      if (bus.ap_ready) bus.ap_start = 0;
      if (bus.rd_start) found = 1;
    end
    chk("t5_started", found, 1);
    bus.mon_tvalid = 1; bus.mon_tready = 1;
    repeat (8) @(negedge aclk);
    chk("t5_beats_pre_reset", bus.beat_count, 8);
    bus.mon_tvalid = 0; bus.mon_tready = 0;
    #2 areset = 1'b1;
    #1;
    chk("t5_idle_in_reset", bus.ap_idle, 1);
    chk("t5_beats_in_reset", bus.beat_count, 0);
    chk("t5_addr_in_reset", bus.rd_addr_offset, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge aclk);
      if (bus.ap_done) nd++;
    end
    chk("t5_no_done", nd, 0);
    do_run(32'd192, 0, 6, 4, 3, 0, 0, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t5_rerun_beats", bc, 3);
    chk("t5_rerun_mismatch", emm, 0);

    do_run(32'd128, 0, 4, 6, 2, 0, 0, 1, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t6_extra_one_start", nrs, 1);
    repeat (3) @(negedge aclk);
    chk("t6_stays_idle", bus.ap_idle, 1);
    do_run(32'd128, 0, 4, 6, 2, 0, 1, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t6_hold_a_starts", nrs, 1);
    do_run(32'd128, 0, 6, 4, 2, 0, 1, 0, st, rs, wd, dn, bc, emm, eto, nrs);
    chk("t6_hold_b_starts", nrs, 1);
    chk("t6_hold_b_latency", rs - st, 2);
    bus.ap_start = 0;
    repeat (2) @(negedge aclk);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] size, lim;
      int rd, wr;
      case ($urandom_range(0, 4))
        0:       size = 32'd0;
        1:       size = 32'($urandom_range(1, 64) * 64);
        2:       size = 32'($urandom_range(1, 5000));
        3:       size = 32'hFFFF_FFFF;
        default: size = 32'($urandom_range(1, 200));
      endcase
      lim = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 80)) : 32'd0;
      rd  = $urandom_range(0, 60);
      wr  = ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 60));
      if (lim != 0 && $urandom_range(0, 3) == 0) wr = -1;
      do_run(size, lim, rd, wr, 0, 1, 0, ($urandom_range(0, 1) == 1),
             st, rs, wd, dn, bc, emm, eto, nrs);
      chk("rand_one_start", nrs, 1);
      repeat ($urandom_range(0, 3)) @(negedge aclk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL global_time_limit t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
